// File: rtl/echo_ranger_array_pkg.sv
// Shared constants and channel FSM encoding for the echo ranger array.
package echo_ranger_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2,
    TMO  = 2'd3
  } ch_state_e;

  localparam int unsigned DEF_NUM_CH    = 2;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_TIMEOUT   = 38000;
  localparam int unsigned DEF_SCALE_NUM = 17;
  localparam int unsigned DEF_SCALE_DEN = 10;
  localparam int unsigned DEF_PERIOD    = 60000;
  localparam int unsigned DEF_TRIG_LEN  = 10;

endpackage

// File: rtl/echo_ranger_array_if.sv
// Sensor-side bus of the echo ranger array: trigger enable, echo lines and results.
interface echo_ranger_array_if #(
  parameter int unsigned NUM_CH = echo_ranger_array_pkg::DEF_NUM_CH,
  parameter int unsigned CNT_W  = echo_ranger_array_pkg::DEF_CNT_W
);

  logic                          en;
  logic [NUM_CH-1:0]             echo;
  logic                          trig;
  logic [NUM_CH*(CNT_W+1)-1:0]   dis_count;
  logic [NUM_CH-1:0]             dis_valid;
  logic [NUM_CH-1:0]             timeout;

  modport master (
    output en,
    output echo,
    input  trig,
    input  dis_count,
    input  dis_valid,
    input  timeout
  );

  modport slave (
    input  en,
    input  echo,
    output trig,
    output dis_count,
    output dis_valid,
    output timeout
  );

endinterface

// File: rtl/echo_ranger_array_channel.sv
// One echo channel: synchronizes the raw echo, measures its high width and
// converts it to a scaled distance, flagging pulses that exceed TIMEOUT.
module echo_channel
  import echo_ranger_array_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned SCALE_NUM = DEF_SCALE_NUM,
  parameter int unsigned SCALE_DEN = DEF_SCALE_DEN
) (
  input  logic             clk_1m,
  input  logic             rst,
  input  logic             i_echo,
  output logic [CNT_W:0]   o_dis_count,
  output logic             o_dis_valid,
  output logic             o_timeout
);

  localparam int unsigned OUT_W  = CNT_W + 1;
  localparam int unsigned PROD_W = CNT_W + 8;

  logic             r_s1;
  logic             r_s2;
  logic             r_primed;
  logic             r_armed;
  ch_state_e        r_state;
  logic [CNT_W-1:0] r_count;

  logic             w_rise;
  logic             w_fall;
  logic [PROD_W-1:0] w_prod;
  logic [OUT_W-1:0]  w_dist;

  // r_armed requires a genuine low sample after reset, so an echo that was
  // already high when reset released is not mistaken for a fresh rise.
  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_primed <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_s1     <= i_echo;
      r_s2     <= r_s1;
      r_primed <= 1'b1;
      if (r_primed && !r_s1) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_rise = r_s1 & ~r_s2 & r_armed;
  assign w_fall = ~r_s1 & r_s2;
  assign w_prod = PROD_W'(r_count) * PROD_W'(SCALE_NUM);
  assign w_dist = OUT_W'(w_prod / PROD_W'(SCALE_DEN));

  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      o_dis_count <= '0;
      o_dis_valid <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_dis_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_count <= CNT_W'(1);
            r_state <= MEAS;
          end else begin
            r_count <= '0;
          end
        end
        MEAS: begin
          if (w_fall) begin
            r_state <= DONE;
          end else if (r_count == CNT_W'(TIMEOUT)) begin
            r_state <= TMO;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        DONE: begin
          o_dis_count <= w_dist;
          o_dis_valid <= 1'b1;
          o_timeout   <= 1'b0;
          r_state     <= IDLE;
        end
        TMO: begin
          o_timeout <= 1'b1;
          if (!r_s1) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/echo_ranger_array.sv
// Multi-channel ultrasonic ranger: shared trigger generator plus NUM_CH
// independent echo-width measurement channels.
module echo_ranger_array
  import echo_ranger_array_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned SCALE_NUM = DEF_SCALE_NUM,
  parameter int unsigned SCALE_DEN = DEF_SCALE_DEN,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned TRIG_LEN  = DEF_TRIG_LEN
) (
  input  logic          clk_1m,
  input  logic          rst,
  echo_ranger_array_if.slave bus
);

  localparam int unsigned OUT_W  = CNT_W + 1;
  localparam int unsigned PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PCNT_W-1:0] r_pcnt;
  logic              r_trig;

  // Period counter only runs while enabled, so a fresh enable always
  // starts with a full trigger pulse.
  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_trig <= 1'b0;
    end else if (!bus.en) begin
      r_pcnt <= '0;
      r_trig <= 1'b0;
    end else begin
      r_trig <= (r_pcnt < PCNT_W'(TRIG_LEN));
      r_pcnt <= (r_pcnt == PCNT_W'(PERIOD - 1)) ? '0 : r_pcnt + PCNT_W'(1);
    end
  end

  assign bus.trig = r_trig;

  logic [OUT_W-1:0]  w_cnt [NUM_CH];
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_tmo;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    echo_channel #(
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT),
      .SCALE_NUM (SCALE_NUM),
      .SCALE_DEN (SCALE_DEN)
    ) u_ch (
      .clk_1m      (clk_1m),
      .rst         (rst),
      .i_echo      (bus.echo[g]),
      .o_dis_count (w_cnt[g]),
      .o_dis_valid (w_valid[g]),
      .o_timeout   (w_tmo[g])
    );

    assign bus.dis_count[g*OUT_W +: OUT_W] = w_cnt[g];
  end

  assign bus.dis_valid = w_valid;
  assign bus.timeout   = w_tmo;

endmodule
